// File: rtl/xalu_pkg.sv
// xalu_pkg: shared constants and types for the nibble-serial ALU sequencer.
//   NIBBLE_W     width of one ALU slice operand
//   OP_*         function codes carried on op / sl_f
//   state_t      sequencer states
package xalu_pkg;

   localparam int NIBBLE_W = 4;

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_AND   = 3'd1;
   localparam logic [2:0] OP_OR    = 3'd2;
   localparam logic [2:0] OP_XOR   = 3'd3;
   localparam logic [2:0] OP_PASSA = 3'd4;
   localparam logic [2:0] OP_PASSB = 3'd5;
   localparam logic [2:0] OP_SHR   = 3'd6;
   localparam logic [2:0] OP_SHL   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/xalu_nibble_seq.sv
// xalu_nibble_seq: runs a word-wide ALU operation through an external 4-bit
// ALU slice, one nibble per clock, chaining the slice carry through a
// register between nibbles.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, op, com, cin      operation request, function code, complement
//                            output mode, word carry-in / shift-in
//   a, b                     word operands (latched on accepted start)
//   busy, done               operation in progress, one-cycle completion
//   result, cout, zero, equ  word result and flags, updated at completion
//   sl_a, sl_b, sl_f, sl_com,
//   sl_ci_left, sl_ci_right  drives to the slice (zero outside RUN)
//   sl_d, sl_co_left,
//   sl_co_right, sl_equ      returns from the slice
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; slice drives held at 0
// RUN     | one nibble per cycle through the slice, NIBBLES cycles
// DONE    | one cycle, done=1, result/flags already updated
module xalu_nibble_seq
   import xalu_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [2:0]              op,
   input  logic                    com,
   input  logic                    cin,
   input  logic [4*NIBBLES-1:0]    a,
   input  logic [4*NIBBLES-1:0]    b,
   output logic                    busy,
   output logic                    done,
   output logic [4*NIBBLES-1:0]    result,
   output logic                    cout,
   output logic                    zero,
   output logic                    equ,
   output logic [NIBBLE_W-1:0]     sl_a,
   output logic [NIBBLE_W-1:0]     sl_b,
   output logic [2:0]              sl_f,
   output logic                    sl_com,
   output logic                    sl_ci_left,
   output logic                    sl_ci_right,
   input  logic [NIBBLE_W-1:0]     sl_d,
   input  logic                    sl_co_left,
   input  logic                    sl_co_right,
   input  logic                    sl_equ
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] pos;
   int               bit_lo;
   logic [2:0]       op_q;
   logic             com_q, cin_q;
   logic [W-1:0]     a_q, b_q;
   logic [W-1:0]     acc_q, acc_d;
   logic             carry_q, carry_d;
   logic             equ_acc_q, equ_run;
   logic [W-1:0]     result_q;
   logic             cout_q, cout_d, zero_q, equ_q;
   logic             is_shr, first, last;

   // SHR walks MSB nibble first so the shift-in ripples downward.
   always_comb begin
      is_shr  = (op_q == OP_SHR);
      first   = (idx_q == '0);
      last    = (idx_q == IDX_LAST);
      pos     = is_shr ? (IDX_LAST - idx_q) : idx_q;
      bit_lo  = int'(pos) * NIBBLE_W;
      carry_d = is_shr ? sl_co_right : sl_co_left;
      equ_run = equ_acc_q & sl_equ;
   end

   always_comb begin
      acc_d = acc_q;
      acc_d[bit_lo +: NIBBLE_W] = sl_d;
   end

   always_comb begin
      cout_d = 1'b0;
      case (op_q)
         OP_ADD, OP_SHL: cout_d = sl_co_left;
         OP_SHR:         cout_d = sl_co_right;
         default:        cout_d = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      busy        = 1'b0;
      done        = 1'b0;
      sl_a        = '0;
      sl_b        = '0;
      sl_f        = '0;
      sl_com      = 1'b0;
      sl_ci_left  = 1'b0;
      sl_ci_right = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_RUN;
         end
         ST_RUN: begin
            busy   = 1'b1;
            sl_a   = a_q[bit_lo +: NIBBLE_W];
            sl_b   = b_q[bit_lo +: NIBBLE_W];
            sl_f   = op_q;
            sl_com = com_q;
            if (is_shr) sl_ci_left  = first ? cin_q : carry_q;
            else        sl_ci_right = first ? cin_q : carry_q;
            if (last) state_d = ST_DONE;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         op_q      <= '0;
         com_q     <= 1'b0;
         cin_q     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         carry_q   <= 1'b0;
         equ_acc_q <= 1'b0;
         result_q  <= '0;
         cout_q    <= 1'b0;
         zero_q    <= 1'b0;
         equ_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  op_q      <= op;
                  com_q     <= com;
                  cin_q     <= cin;
                  a_q       <= a;
                  b_q       <= b;
                  idx_q     <= '0;
                  acc_q     <= '0;
                  carry_q   <= 1'b0;
                  equ_acc_q <= 1'b1;
               end
            end
            ST_RUN: begin
               idx_q     <= last ? '0 : idx_q + IDX_W'(1);
               acc_q     <= acc_d;
               carry_q   <= carry_d;
               equ_acc_q <= equ_run;
               // Only the completed word becomes visible on result.
               if (last) begin
                  result_q <= acc_d;
                  cout_q   <= cout_d;
                  zero_q   <= (acc_d == '0);
                  equ_q    <= equ_run;
               end
            end
            default: ;
         endcase
      end
   end

   assign result = result_q;
   assign cout   = cout_q;
   assign zero   = zero_q;
   assign equ    = equ_q;

endmodule

// File: tb/tb_xalu_nibble_seq.sv
module tb_xalu_nibble_seq;
   import xalu_pkg::*;

   localparam int N = 4;
   localparam int W = 4 * N;

   typedef struct packed {
      logic [W-1:0] res;
      logic         cout;
      logic         zero;
      logic         equ;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [2:0]   op;
   logic         com, cin;
   logic [W-1:0] a, b;
   logic         busy, done;
   logic [W-1:0] result;
   logic         cout, zero, equ;
   logic [3:0]   sl_a, sl_b, sl_d;
   logic [2:0]   sl_f;
   logic         sl_com, sl_ci_left, sl_ci_right;
   logic         sl_co_left, sl_co_right, sl_equ;

   int tests = 0;
   int fails = 0;
   logic [W-1:0] prev_res;

   always #5 clk = ~clk;

   xalu_nibble_seq #(.NIBBLES(N)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .com(com), .cin(cin),
      .a(a), .b(b), .busy(busy), .done(done), .result(result),
      .cout(cout), .zero(zero), .equ(equ),
      .sl_a(sl_a), .sl_b(sl_b), .sl_f(sl_f), .sl_com(sl_com),
      .sl_ci_left(sl_ci_left), .sl_ci_right(sl_ci_right),
      .sl_d(sl_d), .sl_co_left(sl_co_left), .sl_co_right(sl_co_right),
      .sl_equ(sl_equ)
   );

   // Behavioural 4-bit ALU slice.
   logic [4:0] sl_sum;
   logic [3:0] sl_raw;
   assign sl_sum = {1'b0, sl_a} + {1'b0, sl_b} + {4'b0, sl_ci_right};
   always_comb begin
      sl_raw      = 4'h0;
      sl_co_left  = 1'b0;
      sl_co_right = 1'b0;
      case (sl_f)
         3'd0: {sl_co_left, sl_raw} = sl_sum;
         3'd1: sl_raw = sl_a & sl_b;
         3'd2: sl_raw = sl_a | sl_b;
         3'd3: sl_raw = sl_a ^ sl_b;
         3'd4: sl_raw = sl_a;
         3'd5: sl_raw = sl_b;
         3'd6: begin sl_raw = {sl_ci_left, sl_a[3:1]}; sl_co_right = sl_a[0]; end
         default: begin sl_raw = {sl_a[2:0], sl_ci_right}; sl_co_left = sl_a[3]; end
      endcase
      sl_d   = sl_com ? ~sl_raw : sl_raw;
      sl_equ = (sl_a == sl_b);
   end

   // Word-level reference: whole-word arithmetic, no nibbles.
   function automatic exp_t ref_model(input logic [2:0] o, input logic c, input logic ci,
                                      input logic [W-1:0] aa, input logic [W-1:0] bb);
      exp_t e;
      logic [W:0] s;
      e.cout = 1'b0;
      e.res  = '0;
      case (o)
         3'd0: begin
            s = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ci};
            e.res = s[W-1:0];
            e.cout = s[W];
         end
         3'd1: e.res = aa & bb;
         3'd2: e.res = aa | bb;
         3'd3: e.res = aa ^ bb;
         3'd4: e.res = aa;
         3'd5: e.res = bb;
         3'd6: begin e.res = {ci, aa[W-1:1]}; e.cout = aa[0]; end
         default: begin e.res = {aa[W-2:0], ci}; e.cout = aa[W-1]; end
      endcase
      if (c) e.res = ~e.res;
      e.zero = (e.res == '0);
      e.equ  = (aa == bb);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [14:0] sl_vec();
      return {sl_a, sl_b, sl_f, sl_com, sl_ci_left, sl_ci_right};
   endfunction

   task automatic run_op(input string tag, input logic [2:0] o, input logic c,
                         input logic ci, input logic [W-1:0] aa, input logic [W-1:0] bb);
      exp_t e;
      int cyc;
      int busy_cnt;
      logic shr;
      logic [3:0] an, bn;
      e   = ref_model(o, c, ci, aa, bb);
      shr = (o == OP_SHR);
      an  = shr ? aa[W-1 -: 4] : aa[3:0];
      bn  = shr ? bb[W-1 -: 4] : bb[3:0];
      @(negedge clk);
      chk({tag, "_idle_done"}, {31'b0, done}, 0);
      chk({tag, "_idle_sl"}, {17'b0, sl_vec()}, 0);
      start = 1'b1; op = o; com = c; cin = ci; a = aa; b = bb;
      @(negedge clk);
      cyc = 1;
      busy_cnt = 0;
      while (!done && cyc < 4 * N) begin
         if (busy) busy_cnt++;
         if (cyc == 1)
            chk({tag, "_sl_first"}, {17'b0, sl_vec()},
                {17'b0, an, bn, o, c, shr ? ci : 1'b0, shr ? 1'b0 : ci});
         if (cyc == 2)
            chk({tag, "_res_hidden"}, {{(32-W){1'b0}}, result}, {{(32-W){1'b0}}, prev_res});
         // Disturb inputs during RUN: they must not reach the operation.
         start = 1'(($urandom));
         op = 3'($urandom); com = 1'($urandom); cin = 1'($urandom);
         a = W'($urandom); b = W'($urandom);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk({tag, "_latency"}, cyc, N + 1);
      chk({tag, "_busy_cycles"}, busy_cnt, N);
      chk({tag, "_done_busy"}, {30'b0, done, busy}, 32'b10);
      chk({tag, "_done_sl"}, {17'b0, sl_vec()}, 0);
      chk({tag, "_result"}, {{(32-W){1'b0}}, result}, {{(32-W){1'b0}}, e.res});
      chk({tag, "_flags"}, {29'b0, cout, zero, equ}, {29'b0, e.cout, e.zero, e.equ});
      prev_res = e.res;
   endtask

   initial begin
      exp_t e0, e1;
      int ndone, first_k, second_k;
      logic [W-1:0] got [2];
      logic [2:0] ro;
      logic [W-1:0] ra, rb;

      rst = 1'b1; start = 1'b0; op = '0; com = 1'b0; cin = 1'b0; a = '0; b = '0;
      prev_res = '0;
      #1;
      chk("reset_outputs", {9'b0, busy, done, result, cout, zero, equ}, 0);
      chk("reset_sl", {17'b0, sl_vec()}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_op("add1", OP_ADD, 1'b0, 1'b0, 16'h1234, 16'h0FCD);
      chk("add1_const", {result, cout, zero}, {16'h2201, 1'b0, 1'b0});
      run_op("add2", OP_ADD, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
      chk("add2_const", {result, cout, zero}, {16'h0000, 1'b1, 1'b1});
      run_op("shr", OP_SHR, 1'b0, 1'b1, 16'h8001, 16'h0000);
      chk("shr_const", {result, cout}, {16'hC000, 1'b1});
      run_op("shl", OP_SHL, 1'b0, 1'b0, 16'h8001, 16'h0000);
      chk("shl_const", {result, cout}, {16'h0002, 1'b1});
      run_op("xorc", OP_XOR, 1'b1, 1'b0, 16'hAAAA, 16'hAAAA);
      chk("xorc_const", {result, zero, equ}, {16'hFFFF, 1'b0, 1'b1});
      run_op("and_ne", OP_AND, 1'b0, 1'b0, 16'hAAAA, 16'hAAAB);
      chk("and_ne_equ", {31'b0, equ}, 0);

      for (int i = 0; i < 30; i++) begin
         ro = 3'($urandom);
         ra = W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
         run_op("rand", ro, 1'($urandom), 1'($urandom), ra, rb);
      end

      // Start held high for 12 cycles: only IDLE-cycle starts are taken.
      @(negedge clk);
      ndone = 0; first_k = -1; second_k = -1;
      got[0] = '0; got[1] = '0;
      e0 = '0; e1 = '0;
      for (int k = 0; k < 12; k++) begin
         start = 1'b1; op = OP_ADD; com = 1'b0; cin = 1'b0;
         a = W'(32'h0101 * (k + 1));
         b = W'(32'h0011 * k);
         if (k == 0) e0 = ref_model(OP_ADD, 1'b0, 1'b0, a, b);
         if (k == 6) e1 = ref_model(OP_ADD, 1'b0, 1'b0, a, b);
         @(negedge clk);
         if (done) begin
            if (ndone == 0) begin got[0] = result; first_k = k; end
            if (ndone == 1) begin got[1] = result; second_k = k; end
            ndone++;
         end
      end
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("b2b_count", ndone, 2);
      chk("b2b_first_at", first_k, N);
      chk("b2b_second_at", second_k, 2 * N + 2);
      chk("b2b_res0", {16'b0, got[0]}, {16'b0, e0.res});
      chk("b2b_res1", {16'b0, got[1]}, {16'b0, e1.res});
      prev_res = e1.res;

      run_op("pre_rst", OP_XOR, 1'b1, 1'b0, 16'h5A5A, 16'h5A5A);

      // Reset in the third RUN cycle.
      @(negedge clk);
      start = 1'b1; op = OP_ADD; com = 1'b0; cin = 1'b1; a = 16'h7777; b = 16'h1111;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_pre_busy", {31'b0, busy}, 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_outputs", {9'b0, busy, done, result, cout, zero, equ}, 0);
      chk("rst_mid_sl", {17'b0, sl_vec()}, 0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      chk("rst_no_done", ndone, 0);
      prev_res = '0;
      run_op("post_rst", OP_ADD, 1'b0, 1'b0, 16'h0001, 16'h0001);
      chk("post_rst_const", {16'b0, result}, 32'h0002);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
